// File: rtl/seek_cd_acc.sv
// seek_cd_acc: two-stage c/d field-sum pipeline with valid/ready handshakes and an
// ACC_LEN-sample accumulate mode. Define SEEK_CD_SAT_EN for saturating sums and a sat output.

module seek_cd_acc #(
  parameter int unsigned DW      = 32,
  parameter int unsigned F0W     = 7,
  parameter int unsigned F1W     = 13,
  parameter int unsigned F2W     = 13,
  parameter int unsigned ACC_LEN = 4,
  parameter int unsigned CW      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2*DW+1:0] z,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mode,
  output logic [DW-1:0]   c,
  output logic [DW+1:0]   d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            idle,
  output logic [CW-1:0]   cnt
`ifdef SEEK_CD_SAT_EN
  ,
  output logic            sat
`endif
);

  localparam int unsigned ZW  = 2 * DW + 2;
  localparam int unsigned M   = ZW - 1;
  localparam int unsigned SW  = ZW + 2;
  localparam int unsigned P1W = F0W + F1W;
  localparam int unsigned P2W = F0W + F1W + F2W;

  logic [SW-1:0] f0_x, f1_x, f2_x, p1_x, p2_x;
  logic [DW-1:0] cs, s1_c_q, acc_c_q, acc_c_d, sum_c, c_d;
  logic [DW+1:0] ds, s1_d_q, acc_d_q, acc_d_d, sum_d, d_d;
  logic          s1_valid_q, s1_adv, s2_free, accept, last, out_valid_d, mode_q;
  logic [CW-1:0] cnt_d;

  // Bits of z below field 2 carry no information for this stage.
  logic unused_z;
  assign unused_z = ^z;

`ifdef SEEK_CD_SAT_EN
  logic [SW-1:0]  c_raw, d_raw;
  logic [DW:0]    add_c;
  logic [DW+2:0]  add_d;
  logic           cs_sat, s1_sat_q, acc_sat_q, acc_sat_d, add_sat, sat_d;
`endif

  // Fields and nested prefixes, zero-extended to a width that cannot overflow.
  always_comb begin
    f0_x = '0;
    f1_x = '0;
    f2_x = '0;
    p1_x = '0;
    p2_x = '0;
    f0_x[F0W-1:0] = z[M -: F0W];
    f1_x[F1W-1:0] = z[M-F0W -: F1W];
    f2_x[F2W-1:0] = z[M-F0W-F1W -: F2W];
    p1_x[P1W-1:0] = z[M -: P1W];
    p2_x[P2W-1:0] = z[M -: P2W];
  end

`ifdef SEEK_CD_SAT_EN
  always_comb begin
    c_raw  = f0_x + f1_x + f2_x;
    d_raw  = f0_x + p1_x + p2_x;
    cs     = (|c_raw[SW-1:DW])   ? '1 : c_raw[DW-1:0];
    ds     = (|d_raw[SW-1:DW+2]) ? '1 : d_raw[DW+1:0];
    cs_sat = (|c_raw[SW-1:DW]) | (|d_raw[SW-1:DW+2]);
  end

  always_comb begin
    add_c   = {1'b0, acc_c_q} + {1'b0, s1_c_q};
    add_d   = {1'b0, acc_d_q} + {1'b0, s1_d_q};
    sum_c   = add_c[DW]   ? '1 : add_c[DW-1:0];
    sum_d   = add_d[DW+2] ? '1 : add_d[DW+1:0];
    add_sat = s1_sat_q | add_c[DW] | add_d[DW+2];
  end
`else
  always_comb begin
    cs    = DW'(f0_x + f1_x + f2_x);
    ds    = (DW+2)'(f0_x + p1_x + p2_x);
    sum_c = acc_c_q + s1_c_q;
    sum_d = acc_d_q + s1_d_q;
  end
`endif

  // Handshake plumbing
  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign idle     = !s1_valid_q && !out_valid && (cnt == '0);
  assign last     = (cnt == CW'(ACC_LEN - 1));

  // Stage 1: registered sample sums
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_c_q     <= '0;
      s1_d_q     <= '0;
`ifdef SEEK_CD_SAT_EN
      s1_sat_q   <= 1'b0;
`endif
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_c_q     <= cs;
      s1_d_q     <= ds;
`ifdef SEEK_CD_SAT_EN
      s1_sat_q   <= cs_sat;
`endif
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: output register and accumulator next state
  always_comb begin
    c_d         = c;
    d_d         = d;
    out_valid_d = out_valid && !out_ready;
    acc_c_d     = acc_c_q;
    acc_d_d     = acc_d_q;
    cnt_d       = cnt;
`ifdef SEEK_CD_SAT_EN
    acc_sat_d   = acc_sat_q;
    sat_d       = sat;
`endif
    if (s1_adv) begin
      if (!mode_q) begin
        c_d         = s1_c_q;
        d_d         = s1_d_q;
        out_valid_d = 1'b1;
`ifdef SEEK_CD_SAT_EN
        sat_d       = s1_sat_q;
`endif
      end else if (last) begin
        c_d         = sum_c;
        d_d         = sum_d;
        out_valid_d = 1'b1;
        acc_c_d     = '0;
        acc_d_d     = '0;
        cnt_d       = '0;
`ifdef SEEK_CD_SAT_EN
        sat_d       = acc_sat_q | add_sat;
        acc_sat_d   = 1'b0;
`endif
      end else begin
        acc_c_d     = sum_c;
        acc_d_d     = sum_d;
        cnt_d       = cnt + CW'(1);
`ifdef SEEK_CD_SAT_EN
        acc_sat_d   = acc_sat_q | add_sat;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c         <= '0;
      d         <= '0;
      out_valid <= 1'b0;
      acc_c_q   <= '0;
      acc_d_q   <= '0;
      cnt       <= '0;
`ifdef SEEK_CD_SAT_EN
      acc_sat_q <= 1'b0;
      sat       <= 1'b0;
`endif
    end else begin
      c         <= c_d;
      d         <= d_d;
      out_valid <= out_valid_d;
      acc_c_q   <= acc_c_d;
      acc_d_q   <= acc_d_d;
      cnt       <= cnt_d;
`ifdef SEEK_CD_SAT_EN
      acc_sat_q <= acc_sat_d;
      sat       <= sat_d;
`endif
    end
  end

  // Mode only switches between windows so a window never mixes modes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else if (idle) begin
      mode_q <= mode;
    end
  end

endmodule
